// File: rtl/ufi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ufi_ram_arbiter
// Brief    : Shares the UfiBus RAM slave between masters; video fixed priority,
//            others round-robin, one burst per grant, read data routed to owner.
// Revision : 1.0
// ============================================================================
module ufi_ram_arbiter #(
    parameter int pUfiBusWidth = 12,
    parameter int pBusAdrsBit  = 32,
    parameter int pMasterNum   = 4,
    parameter int pVideoPort   = 2,
    parameter int pMaxBurst    = 64,
    parameter int pOutstdWidth = 5
) (
    input  logic                               iUfiClk,
    input  logic                               iUfiRst,
    input  logic [pMasterNum*pUfiBusWidth-1:0] iMUfiWd,
    input  logic [pMasterNum*pBusAdrsBit-1:0]  iMUfiAdrs,
    input  logic [pMasterNum-1:0]              iMUfiWEd,
    input  logic [pMasterNum-1:0]              iMUfiREd,
    input  logic [pMasterNum-1:0]              iMUfiVd,
    input  logic [pMasterNum-1:0]              iMUfiCmd,
    output logic [pMasterNum-1:0]              oMUfiRdy,
    output logic [pUfiBusWidth-1:0]            oMUfiRd,
    output logic [pMasterNum-1:0]              oMUfiREd,
    output logic [pUfiBusWidth-1:0]            oSUfiWd,
    output logic [pBusAdrsBit-1:0]             oSUfiAdrs,
    output logic                               oSUfiWEd,
    output logic                               oSUfiREd,
    output logic                               oSUfiCmd,
    input  logic [pUfiBusWidth-1:0]            iSUfiRd,
    input  logic                               iSUfiREd,
    input  logic                               iSUfiRdy,
    output logic [pMasterNum-1:0]              oGrant,
    output logic                               oBusy
);

    localparam int IW = (pMasterNum > 1) ? $clog2(pMasterNum) : 1;
    localparam int BW = $clog2(pMaxBurst + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [pMasterNum-1:0]   r_grant;
    logic [IW-1:0]           r_owner;
    logic [IW-1:0]           r_rr_ptr;
    logic [BW-1:0]           r_beat_cnt;
    logic [pOutstdWidth-1:0] r_outstd;

    logic                    w_in_grant;
    logic                    w_full;
    logic                    w_rdy;
    logic [pUfiBusWidth-1:0] w_wd;
    logic [pBusAdrsBit-1:0]  w_adrs;
    logic                    w_wed;
    logic                    w_red;
    logic                    w_vd;
    logic                    w_cmd;
    logic                    w_acc;
    logic                    w_rd_acc;
    logic                    w_ret;
    logic                    w_exit;
    logic [pOutstdWidth-1:0] w_outstd_nxt;
    logic [IW-1:0]           w_win_idx;
    logic [pMasterNum-1:0]   w_win_onehot;
    logic                    w_found;

    assign w_in_grant = (r_state == GRANT);
    assign w_full     = &r_outstd;
    assign w_rdy      = w_in_grant & iSUfiRdy & ~w_full;

    always_comb begin
        w_wd   = '0;
        w_adrs = '0;
        w_wed  = 1'b0;
        w_red  = 1'b0;
        w_vd   = 1'b0;
        w_cmd  = 1'b0;
        for (int i = 0; i < pMasterNum; i++) begin
            if (r_owner == IW'(i)) begin
                w_wd   = iMUfiWd[i*pUfiBusWidth +: pUfiBusWidth];
                w_adrs = iMUfiAdrs[i*pBusAdrsBit +: pBusAdrsBit];
                w_wed  = iMUfiWEd[i];
                w_red  = iMUfiREd[i];
                w_vd   = iMUfiVd[i];
                w_cmd  = iMUfiCmd[i];
            end
        end
    end

    assign w_acc    = (w_wed | w_red) & w_rdy;
    assign w_rd_acc = w_red & w_rdy;
    // Returns with nothing outstanding are spurious and dropped.
    assign w_ret    = iSUfiREd & (r_outstd != '0);
    assign w_exit   = w_in_grant &
                      (~w_vd | (w_acc & (r_beat_cnt == BW'(pMaxBurst - 1))));

    always_comb begin
        w_outstd_nxt = r_outstd;
        if (w_rd_acc && !w_ret) begin
            w_outstd_nxt = r_outstd + pOutstdWidth'(1);
        end else if (!w_rd_acc && w_ret) begin
            w_outstd_nxt = r_outstd - pOutstdWidth'(1);
        end
    end

    // Round-robin scan starts just after the last non-video winner.
    always_comb begin
        w_win_idx = r_rr_ptr;
        w_found   = 1'b0;
        for (int k = 1; k <= pMasterNum; k++) begin
            int j;
            j = int'(r_rr_ptr) + k;
            if (j >= pMasterNum) begin
                j = j - pMasterNum;
            end
            if (!w_found && iMUfiVd[j]) begin
                w_win_idx = IW'(j);
                w_found   = 1'b1;
            end
        end
        if (iMUfiVd[pVideoPort]) begin
            w_win_idx = IW'(pVideoPort);
        end
        w_win_onehot = '0;
        for (int i = 0; i < pMasterNum; i++) begin
            w_win_onehot[i] = (w_win_idx == IW'(i));
        end
    end

    always_ff @(posedge iUfiClk or posedge iUfiRst) begin
        if (iUfiRst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= IW'(pMasterNum - 1);
            r_beat_cnt <= '0;
            r_outstd   <= '0;
        end else begin
            r_outstd <= w_outstd_nxt;
            case (r_state)
                IDLE: begin
                    if (|iMUfiVd) begin
                        r_state    <= GRANT;
                        r_grant    <= w_win_onehot;
                        r_owner    <= w_win_idx;
                        r_beat_cnt <= '0;
                        if (w_win_idx != IW'(pVideoPort)) begin
                            r_rr_ptr <= w_win_idx;
                        end
                    end
                end
                GRANT: begin
                    if (w_exit) begin
                        r_grant    <= '0;
                        r_beat_cnt <= '0;
                        r_state    <= (w_outstd_nxt != '0) ? DRAIN : IDLE;
                    end else if (w_acc) begin
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                    end
                end
                DRAIN: begin
                    if (w_outstd_nxt == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        oMUfiRdy = '0;
        oMUfiREd = '0;
        for (int i = 0; i < pMasterNum; i++) begin
            oMUfiRdy[i] = w_rdy & (r_owner == IW'(i));
            oMUfiREd[i] = w_ret & (r_owner == IW'(i));
        end
    end

    assign oMUfiRd   = iSUfiRd;
    assign oSUfiWd   = w_in_grant ? w_wd   : '0;
    assign oSUfiAdrs = w_in_grant ? w_adrs : '0;
    assign oSUfiCmd  = w_in_grant & w_cmd;
    assign oSUfiWEd  = w_wed & w_rdy;
    assign oSUfiREd  = w_red & w_rdy;
    assign oGrant    = r_grant;
    assign oBusy     = (r_state != IDLE);

endmodule
`default_nettype wire
